// File: rtl/mania_pkg.sv
// Shared definitions for the rhythm-game chart datapath: lane count, chart word
// format and the recorder state encoding.
package mania_pkg;

  localparam int LANES  = 4;
  localparam int WORD_W = LANES;

  // One chart row lasts readspeed x fallspeed clocks of the game controller.
  localparam int ROW_TICKS_DEFAULT = 112_000_000;

  typedef logic [WORD_W-1:0] chart_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECORD,
    ST_FLUSH,
    ST_DONE
  } rec_state_e;

endpackage

// File: rtl/chart_recorder_if.sv
// Write port of the dual-port chart RAM: the recorder drives it, the RAM sinks it.
interface chart_recorder_if #(
  parameter int ADDR_W = 11
);
  import mania_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  chart_word_t       wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/key_sync_edge.sv
// Brings one asynchronous lane key into the clk domain and emits a single-cycle
// registered pulse on each press onset.
module key_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/chart_recorder.sv
// Records live lane presses as one 4-bit chart word per ROW_TICKS clocks into
// the chart RAM write port.
module chart_recorder
  import mania_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int ROW_TICKS = ROW_TICKS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  key0,
  input  logic                  key1,
  input  logic                  key2,
  input  logic                  key3,
  chart_recorder_if.master      wr,
  output logic                  recording,
  output logic                  done,
  output logic [ADDR_W:0]       rows_written
);

  localparam int TICK_W = $clog2(ROW_TICKS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ROW_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  logic [LANES-1:0] keys;
  logic [LANES-1:0] edges;

  assign keys = {key3, key2, key1, key0};

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    key_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .key_in (keys[l]),
      .pulse  (edges[l])
    );
  end

  rec_state_e        state_q,     state_d;
  logic [TICK_W-1:0] tick_q,      tick_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  chart_word_t       latch_q,     latch_d;
  logic [ADDR_W:0]   rows_q,      rows_d;
  logic              wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  chart_word_t       wr_data_q,   wr_data_d;
  logic              recording_q, recording_d;
  logic              done_q,      done_d;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    addr_d      = addr_q;
    latch_d     = latch_q;
    rows_d      = rows_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    recording_d = (state_q == ST_RECORD) || (state_q == ST_FLUSH);
    done_d      = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_d = ST_RECORD;
          tick_d  = '0;
          addr_d  = '0;
          latch_d = '0;
          rows_d  = '0;
        end
      end

      ST_RECORD: begin
        if (tick_q == TICK_LAST) begin
          // Row boundary: the regular row write takes priority over a stop.
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = latch_q | edges;
          rows_d    = rows_q + (ADDR_W + 1)'(1);
          latch_d   = '0;
          tick_d    = '0;
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (stop) state_d = ST_FLUSH;
          end
        end else begin
          latch_d = latch_q | edges;
          tick_d  = tick_q + TICK_W'(1);
          if (stop) state_d = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // Partial row is committed even when empty so the chart length is exact.
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = latch_q | edges;
        rows_d    = rows_q + (ADDR_W + 1)'(1);
        latch_d   = '0;
        state_d   = ST_DONE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      addr_q      <= '0;
      latch_q     <= '0;
      rows_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      recording_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      addr_q      <= addr_d;
      latch_q     <= latch_d;
      rows_q      <= rows_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      recording_q <= recording_d;
      done_q      <= done_d;
    end
  end

  assign wr.wr_en      = wr_en_q;
  assign wr.wr_addr    = wr_addr_q;
  assign wr.wr_data    = wr_data_q;
  assign recording     = recording_q;
  assign done          = done_q;
  assign rows_written  = rows_q;

endmodule

// File: tb/tb_chart_recorder.sv
// Bench for chart_recorder: directed and randomized recordings compared with a
// row-window model built from key sample history.
module tb_chart_recorder;

  localparam int AW    = 3;
  localparam int RT    = 8;
  localparam int NROWS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop;
  logic          key0, key1, key2, key3;
  logic          recording, done;
  logic [AW:0]   rows_written;

  chart_recorder_if #(.ADDR_W(AW)) wr_if ();

  chart_recorder #(.ADDR_W(AW), .ROW_TICKS(RT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .key0         (key0),
    .key1         (key1),
    .key2         (key2),
    .key3         (key3),
    .wr           (wr_if.master),
    .recording    (recording),
    .done         (done),
    .rows_written (rows_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  logic [3:0] ksamp [0:65535];

  always @(posedge clk) begin
    if (cyc < 65534) ksamp[cyc+1] <= {key3, key2, key1, key0};
    cyc <= cyc + 1;
  end

  int         w_edge [$];
  logic [AW-1:0] w_addr [$];
  logic [3:0] w_data [$];
  int         done_edge = -1;
  logic       done_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_if.wr_en === 1'b1) begin
      w_edge.push_back(cyc);
      w_addr.push_back(wr_if.wr_addr);
      w_data.push_back(wr_if.wr_data);
    end
    if (done === 1'b1 && done_prev !== 1'b1 && done_edge < 0) done_edge = cyc;
    done_prev = done;
  end

  int total = 0;
  int bad   = 0;
  logic [3:0] key_plan [0:127];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Press onsets (per lane) whose edge-detect cycle falls in row ticks lo..hi of
  // a recording started at edge t: a key first sampled high at edge k reaches
  // the latch three clocks later, i.e. in the cycle with tick index k+2-t.
  function automatic logic [3:0] onsets(int t, int lo, int hi);
    logic [3:0] res = 4'b0000;
    for (int k = (t > 8 ? t - 6 : 1); k <= cyc && k < 65535; k++) begin
      int tk = k + 2 - t;
      if (tk >= lo && tk <= hi) res |= ksamp[k] & ~ksamp[k-1];
    end
    return res;
  endfunction

  task automatic clear_log();
    w_edge.delete();
    w_addr.delete();
    w_data.delete();
    done_edge = -1;
  endtask

  task automatic random_plan();
    logic [3:0] cur = 4'b0000;
    for (int i = 0; i < 128; i++) begin
      for (int l = 0; l < 4; l++)
        if ($urandom_range(0, 5) == 0) cur[l] = ~cur[l];
      key_plan[i] = cur;
    end
  endtask

  // Drive one recording (stop_tick < 0: no stop) and compare every RAM write,
  // the final row count and the done timing against the row-window model.
  task automatic record_run(input string name, input int stop_tick, input int ncyc);
    int t = 0;
    int nnorm;
    int e_edge [$];
    int e_addr [$];
    logic [3:0] e_data [$];
    int n;
    @(negedge clk);
    clear_log();
    for (int i = 0; i < ncyc; i++) begin
      if (i > 0) @(negedge clk);
      start = (i == 0);
      stop  = (stop_tick >= 0) && (i == stop_tick + 1);
      {key3, key2, key1, key0} = key_plan[i];
      if (i == 0) t = cyc + 1;
    end
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    {key3, key2, key1, key0} = 4'b0000;
    repeat (3) @(negedge clk);

    if (stop_tick < 0) nnorm = NROWS;
    else nnorm = (stop_tick % RT == RT - 1) ? stop_tick / RT + 1 : stop_tick / RT;
    if (nnorm > NROWS) nnorm = NROWS;
    for (int r = 0; r < nnorm; r++) begin
      e_edge.push_back(t + RT * (r + 1));
      e_addr.push_back(r);
      e_data.push_back(onsets(t, RT * r, RT * r + RT - 1));
    end
    if (stop_tick >= 0 && nnorm < NROWS) begin
      e_edge.push_back(t + stop_tick + 2);
      e_addr.push_back(nnorm);
      e_data.push_back(onsets(t, RT * nnorm, stop_tick + 1));
    end

    check({name, ".nwrites"}, w_edge.size(), e_edge.size());
    n = (w_edge.size() < e_edge.size()) ? w_edge.size() : e_edge.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.addr[%0d]", name, i), w_addr[i], e_addr[i]);
      check($sformatf("%s.data[%0d]", name, i), w_data[i], e_data[i]);
      check($sformatf("%s.when[%0d]", name, i), w_edge[i] - t, e_edge[i] - t);
    end
    check({name, ".rows_written"}, rows_written, e_edge.size());
    check({name, ".done"}, done, 1'b1);
    check({name, ".recording"}, recording, 1'b0);
    if (e_edge.size() > 0)
      check({name, ".done_timing"}, done_edge - t, e_edge[e_edge.size()-1] + 1 - t);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ksamp[i] = 4'b0000;
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    {key3, key2, key1, key0} = 4'b0000;
    #22 rst = 1'b1;

    // Reset state and idle behaviour
    clear_log();
    repeat (20) @(negedge clk);
    check("idle.wr_en", wr_if.wr_en, 1'b0);
    check("idle.wr_addr", wr_if.wr_addr, 0);
    check("idle.wr_data", wr_if.wr_data, 0);
    check("idle.recording", recording, 1'b0);
    check("idle.done", done, 1'b0);
    check("idle.rows_written", rows_written, 0);
    check("idle.no_writes", w_edge.size(), 0);

    // key0 and key2 tapped in row 0, key1 held across rows 0-2, stop at row 2 tick 3
    for (int i = 0; i < 128; i++) key_plan[i] = 4'b0000;
    for (int i = 2; i <= 3; i++) key_plan[i][0] = 1'b1;
    key_plan[4][2] = 1'b1;
    for (int i = 1; i <= 24; i++) key_plan[i][1] = 1'b1;
    record_run("dir_stop", 2 * RT + 3, 2 * RT + 8);
    if (w_data.size() >= 3) begin
      check("dir_stop.row0", w_data[0], 4'b0111);
      check("dir_stop.row1", w_data[1], 4'b0000);
      check("dir_stop.flush_addr", w_addr[2], 2);
      check("dir_stop.flush_data", w_data[2], 4'b0000);
    end
    check("dir_stop.rows3", rows_written, 3);

    // Full chart without stop: exactly NROWS writes and no wrap
    for (int i = 0; i < 128; i++) key_plan[i] = 4'b0000;
    key_plan[60][3] = 1'b1;
    record_run("dir_full", -1, NROWS * RT + 6);
    check("dir_full.rows8", rows_written, NROWS);
    if (w_addr.size() > 0) check("dir_full.last_addr", w_addr[w_addr.size()-1], NROWS - 1);
    clear_log();
    repeat (12) @(negedge clk);
    check("dir_full.no_wrap", w_edge.size(), 0);

    // Stop exactly on a row's last tick
    random_plan();
    record_run("dir_lasttick", RT - 1, RT + 6);

    // Reset in the middle of a recording at tick 5
    random_plan();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    {key3, key2, key1, key0} = 4'b0000;
    @(negedge clk);
    check("rst_mid.wr_en", wr_if.wr_en, 1'b0);
    check("rst_mid.recording", recording, 1'b0);
    check("rst_mid.rows_written", rows_written, 0);
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    repeat (30) @(negedge clk);
    check("rst_mid.no_writes", w_edge.size(), 0);
    record_run("rst_restart", 10, 16);
    if (w_addr.size() > 0) check("rst_restart.first_addr", w_addr[0], 0);

    // Randomized recordings
    for (int r = 0; r < 8; r++) begin
      int st;
      random_plan();
      st = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, NROWS * RT - 2));
      record_run($sformatf("rand%0d", r), st, (st < 0) ? NROWS * RT + 6 : st + 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chart_recorder.md
# chart_recorder

Captures live key presses on the four lanes and writes them as a 4-bit-per-row chart into a block RAM. This is the write side of the chart format that the game controller reads back: one RAM word per chart row, bit n = note on lane n, one row per `ROW_TICKS` clocks. It sits between the key debouncers and a dual-port chart RAM whose read port feeds the game controller.

## Interface
- `ADDR_W`, 11, chart RAM address width; capacity 2^ADDR_W rows
- `ROW_TICKS`, 112_000_000, clocks per chart row; must be ≥ 2
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  level, sampled each clock; begins a recording
- `stop`  in  1  level, sampled each clock; ends a recording
- `key0`..`key3`  in  1 each  debounced lane keys, asynchronous to `clk`, active-high
- `wr_en`  out  1  RAM write strobe, one-cycle pulse per row
- `wr_addr`  out  ADDR_W  RAM write address
- `wr_data`  out  4  row word: {lane3, lane2, lane1, lane0}
- `recording`  out  1  high in RECORD and FLUSH
- `done`  out  1  high in DONE
- `rows_written`  out  ADDR_W+1  rows committed in the current or last recording

## Operation
- Each key passes through a 2-FF synchroniser, then rising-edge detection. Only press onsets count; a held key produces a note only in the row where it went high.
- States: IDLE, RECORD, FLUSH, DONE.
- IDLE/DONE: `start`=1 and `stop`=0 → RECORD. Row address, tick counter, lane latch and `rows_written` clear to 0. `start` and `stop` both high → no transition.
- RECORD: the tick counter runs 0..ROW_TICKS-1. A detected edge sets the lane latch bit. At the last tick, write the row as latch OR the current-cycle edges, then clear the latch, reset the tick counter, increment the address and increment `rows_written`.
- RECORD, `stop`=1 → FLUSH. `start` is ignored while in RECORD.
- FLUSH: lasts one cycle. Writes the partial row (latch OR current edges) at the current address, even if the word is all-zero. Increments `rows_written`, then → DONE.
- Full: writing address 2^ADDR_W-1 (normal row or flush) → DONE. The address never wraps.
- If `stop` arrives on a last-tick cycle, the normal row write wins. Move to FLUSH only if the row is not full; if full, go to DONE.
- `rows_written` has one more bit than the address, so a full chart reads 2^ADDR_W.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `recording`=0, `done`=0, `rows_written`=0, state IDLE, synchronisers 0. Asserting reset mid-recording aborts with no further writes.
- All outputs are registered.
- `start` sampled high at edge t → state RECORD from edge t, tick counter 0 in the cycle after t.
- The first `wr_en` is visible ROW_TICKS cycles after t+1, i.e. in the cycle following tick ROW_TICKS-1. Later rows follow every ROW_TICKS cycles.
- `wr_addr` and `wr_data` are valid only while `wr_en`=1. They hold their values otherwise.
- Key-to-latch latency is 3 clocks (2 sync + edge). A press is attributed to the row whose window holds its edge-detect cycle.
- After `stop` is sampled, the FLUSH write appears on the next cycle's outputs, and `done` rises one cycle later.

## Structure
- Shared package `mania_pkg`:
  - `LANES`=4
  - `ROW_TICKS_DEFAULT` (= readspeed × fallspeed used by the game controller)
  - the state enum
  - the chart word width (4)
- Sub-module `key_sync_edge`: 2-FF synchroniser plus rising-edge pulse, instantiated once per lane.
- Target size: about 200 lines of RTL in total.

## Test plan
All scenarios use `ROW_TICKS`=8 and `ADDR_W`=3.
- Reset then idle 20 cycles → all outputs 0, no `wr_en`.
- Pulse `start`, press `key0` once and `key2` once inside row 0, nothing in row 1 → writes addr 0 data 4'b0101, then addr 1 data 4'b0000, 8 cycles apart. `rows_written`=2.
- Hold `key1` across rows 0–2 → only row 0 has bit1 set; rows 1–2 are 0.
- `stop` at tick 3 of row 2 → rows 0, 1 written normally, then FLUSH writes addr 2 with partial data. `done`=1, `rows_written`=3.
- Record with no `stop` → exactly 8 writes, addr 0..7. `done`=1, `rows_written`=8, no wrap to addr 0.
- Reset mid-RECORD at tick 5 → `wr_en` never pulses again. A later `start` writes its first row at addr 0.
